// File: rtl/hall_pkg.sv
// Shared constants for the hall call register: default sizing, direction
// encoding of the dispatcher acknowledge, and a popcount helper.
package hall_pkg;

  localparam int N_FLOORS_DEF = 11;
  localparam int DEBOUNCE_DEF = 4;
  localparam int PCNT_W       = 5;
  localparam int DEB_CNT_W    = 4;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  function automatic logic [PCNT_W-1:0] count_ones(input logic [31:0] v);
    logic [PCNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) begin
      c = c + PCNT_W'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One hall button: 2-flop synchronizer, stability counter and a single-cycle
// pulse on the edge where the debounced level goes high.
module btn_debounce
  import hall_pkg::*;
#(
  parameter int DEBOUNCE = DEBOUNCE_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_rise
);

  logic                 r_sync1;
  logic                 r_sync2;
  logic                 r_level;
  logic [DEB_CNT_W-1:0] r_cnt;
  logic                 w_differ;
  logic                 w_done;

  assign w_differ = (r_sync2 != r_level);
  // The pulse is combinational so the pending bit sets on the same edge the level flips.
  assign w_done   = w_differ && (r_cnt == DEB_CNT_W'(DEBOUNCE - 1));
  assign o_rise   = w_done && r_sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      if (!w_differ) begin
        r_cnt <= '0;
      end else if (w_done) begin
        r_cnt   <= '0;
        r_level <= r_sync2;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/hall_call_register.sv
// Latches debounced hall UP/DOWN presses as pending calls per floor and clears
// them on rising edges of the dispatcher acknowledge.
module hall_call_register
  import hall_pkg::*;
#(
  parameter int N_FLOORS = N_FLOORS_DEF,
  parameter int DEBOUNCE = DEBOUNCE_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_FLOORS-1:0] up_btn,
  input  logic [N_FLOORS-1:0] dn_btn,
  input  logic [N_FLOORS-1:0] offFloorReq,
  input  logic [N_FLOORS-1:0] offUPorDOWN,
  output logic [N_FLOORS-1:0] FloorReq,
  output logic [N_FLOORS-1:0] U,
  output logic [N_FLOORS-1:0] D,
  output logic [PCNT_W-1:0]   pending_count
);

  // No UP call from the top floor, no DOWN call from the ground floor.
  localparam logic [N_FLOORS-1:0] UP_MASK = ~(N_FLOORS'(1) << (N_FLOORS - 1));
  localparam logic [N_FLOORS-1:0] DN_MASK = ~N_FLOORS'(1);

  logic [N_FLOORS-1:0] r_u;
  logic [N_FLOORS-1:0] r_d;
  logic [N_FLOORS-1:0] r_floor;
  logic [PCNT_W-1:0]   r_count;
  logic [N_FLOORS-1:0] r_ack_prev;
  logic                r_ack_armed;

  logic [N_FLOORS-1:0] w_up_rise;
  logic [N_FLOORS-1:0] w_dn_rise;
  logic [N_FLOORS-1:0] w_ack_rise;
  logic [N_FLOORS-1:0] w_clr_u;
  logic [N_FLOORS-1:0] w_clr_d;
  logic [N_FLOORS-1:0] w_u_nxt;
  logic [N_FLOORS-1:0] w_d_nxt;
  logic [PCNT_W-1:0]   w_count_nxt;

  // The armed flag keeps an acknowledge already high at reset release from
  // looking like a fresh rising edge.
  assign w_ack_rise = offFloorReq & ~r_ack_prev & {N_FLOORS{r_ack_armed}};

  for (genvar g = 0; g < N_FLOORS; g++) begin : g_floor
    btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_up_deb (
      .clk    (clk),
      .rst    (rst),
      .i_btn  (up_btn[g]),
      .o_rise (w_up_rise[g])
    );
    btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_dn_deb (
      .clk    (clk),
      .rst    (rst),
      .i_btn  (dn_btn[g]),
      .o_rise (w_dn_rise[g])
    );
    assign w_clr_u[g] = w_ack_rise[g] && (offUPorDOWN[g] == DIR_UP);
    assign w_clr_d[g] = w_ack_rise[g] && (offUPorDOWN[g] == DIR_DN);
  end

  // OR-ing the set after the clear lets a same-edge press win over an acknowledge.
  assign w_u_nxt     = ((r_u & ~w_clr_u) | w_up_rise) & UP_MASK;
  assign w_d_nxt     = ((r_d & ~w_clr_d) | w_dn_rise) & DN_MASK;
  assign w_count_nxt = count_ones(32'(w_u_nxt)) + count_ones(32'(w_d_nxt));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_u         <= '0;
      r_d         <= '0;
      r_floor     <= '0;
      r_count     <= '0;
      r_ack_prev  <= '0;
      r_ack_armed <= 1'b0;
    end else begin
      r_u         <= w_u_nxt;
      r_d         <= w_d_nxt;
      r_floor     <= w_u_nxt | w_d_nxt;
      r_count     <= w_count_nxt;
      r_ack_prev  <= offFloorReq;
      r_ack_armed <= 1'b1;
    end
  end

  assign U             = r_u;
  assign D             = r_d;
  assign FloorReq      = r_floor;
  assign pending_count = r_count;

endmodule
